// File: rtl/channel_encoder_output.sv
// Quadrature / pulse-direction encoder emulation channel.
// Emits a programmed number of edges at a programmed per-edge period.
module channel_encoder_output #(
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic             pe_enc_clk,
  input  logic             pe_enc_rst,
  input  logic             pe_enc_logic_clr,
  input  logic             r_eo_start,
  input  logic             r_eo_stop,
  input  logic             r_eo_dir,
  input  logic             r_eo_mode,
  input  logic             r_eo1p,
  input  logic             r_eo1np,
  input  logic [CNT_W-1:0] r_eo_edges,
  input  logic [DIV_W-1:0] r_eo_div,
  output logic             ec1po,
  output logic             ec1no,
  output logic             eo_busy,
  output logic             eo_done,
  output logic [CNT_W-1:0] r_eo_remain
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [1:0]       phase_nx;
  logic             raw_a;
  logic             raw_b;
  logic [CNT_W-1:0] remain;
  logic [DIV_W-1:0] divcnt;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_eff;
  logic             dir_q;
  logic             mode_q;

  assign div_eff  = (r_eo_div == '0) ? DIV_W'(1) : r_eo_div;
  assign phase_nx = dir_q ? phase - 2'd1 : phase + 2'd1;

  always_ff @(posedge pe_enc_clk) begin
    if (pe_enc_rst || pe_enc_logic_clr) begin
      state   <= IDLE;
      phase   <= 2'd0;
      raw_a   <= 1'b0;
      raw_b   <= 1'b0;
      remain  <= '0;
      divcnt  <= '0;
      div_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
      eo_done <= 1'b0;
    end else begin
      eo_done <= 1'b0;
      case (state)
        IDLE: begin
          if (r_eo_start && !r_eo_stop) begin
            if (r_eo_edges == '0) begin
              eo_done <= 1'b1;
            end else begin
              state  <= RUN;
              dir_q  <= r_eo_dir;
              mode_q <= r_eo_mode;
              div_q  <= div_eff;
              remain <= r_eo_edges;
              divcnt <= div_eff - DIV_W'(1);
              // pulse/dir shows direction as a level for the whole run
              if (r_eo_mode) raw_b <= r_eo_dir;
            end
          end
        end
        RUN: begin
          if (r_eo_stop) begin
            state <= IDLE;
          end else if (divcnt == '0) begin
            phase  <= phase_nx;
            remain <= remain - CNT_W'(1);
            divcnt <= div_q - DIV_W'(1);
            if (mode_q) begin
              raw_a <= ~raw_a;
            end else begin
              raw_a <= phase_nx[0] ^ phase_nx[1];
              raw_b <= phase_nx[1];
            end
            if (remain == CNT_W'(1)) begin
              state   <= IDLE;
              eo_done <= 1'b1;
            end
          end else begin
            divcnt <= divcnt - DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign eo_busy     = (state == RUN);
  assign r_eo_remain = remain;
  assign ec1po       = raw_a ^ r_eo1p;
  assign ec1no       = raw_b ^ r_eo1np;

endmodule

// File: tb/tb_channel_encoder_output.sv
// Randomized self-checking bench for channel_encoder_output.
// Reference model schedules edges at T + k*D from the start clock.
module tb_channel_encoder_output;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        dir = 1'b0;
  logic        mode = 1'b0;
  logic        eo1p = 1'b0;
  logic        eo1np = 1'b0;
  logic [15:0] edges = '0;
  logic [15:0] div = '0;
  logic        ec1po;
  logic        ec1no;
  logic        eo_busy;
  logic        eo_done;
  logic [15:0] remain;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // reference model state
  bit m_run, m_a, m_b, m_done, m_dir, m_mode;
  int m_phase, m_remain, m_t, m_d;
  bit qa [4] = '{0, 1, 1, 0};
  bit qb [4] = '{0, 0, 1, 1};

  channel_encoder_output #(.CNT_W(16), .DIV_W(16)) dut (
    .pe_enc_clk      (clk),
    .pe_enc_rst      (rst),
    .pe_enc_logic_clr(clr),
    .r_eo_start      (start),
    .r_eo_stop       (stop),
    .r_eo_dir        (dir),
    .r_eo_mode       (mode),
    .r_eo1p          (eo1p),
    .r_eo1np         (eo1np),
    .r_eo_edges      (edges),
    .r_eo_div        (div),
    .ec1po           (ec1po),
    .ec1no           (ec1no),
    .eo_busy         (eo_busy),
    .eo_done         (eo_done),
    .r_eo_remain     (remain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // advance the model over the upcoming clock edge number cyc
  function automatic void model_step();
    m_done = 1'b0;
    if (rst || clr) begin
      m_run = 0; m_phase = 0; m_a = 0; m_b = 0;
      m_remain = 0; m_dir = 0; m_mode = 0; m_d = 1;
    end else if (!m_run) begin
      if (start && !stop) begin
        if (edges == 0) begin
          m_done = 1'b1;
        end else begin
          m_run = 1; m_t = cyc; m_remain = int'(edges);
          m_d = (div == 0) ? 1 : int'(div);
          m_dir = dir; m_mode = mode;
          if (mode) m_b = dir;
        end
      end
    end else if (stop) begin
      m_run = 0;
    end else if ((cyc - m_t) % m_d == 0) begin
      m_phase = (m_phase + (m_dir ? 3 : 1)) % 4;
      if (m_mode) m_a = ~m_a;
      else begin
        m_a = qa[m_phase];
        m_b = qb[m_phase];
      end
      m_remain--;
      if (m_remain == 0) begin
        m_run = 0;
        m_done = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    cyc++;
    model_step();
    @(posedge clk);
    #1;
    chk("ec1po", 32'(ec1po), 32'(m_a ^ eo1p));
    chk("ec1no", 32'(ec1no), 32'(m_b ^ eo1np));
    chk("busy", 32'(eo_busy), 32'(m_run));
    chk("done", 32'(eo_done), 32'(m_done));
    chk("remain", 32'(remain), 32'(m_remain));
  endtask

  task automatic settle();
    int n = 0;
    while (m_run && n < 5000) begin
      tick();
      n++;
    end
    chk("settle_timeout", 32'(m_run), 32'd0);
  endtask

  task automatic scen(input int e, input int d, input bit dr, input bit md,
                      input bit p1, input bit p2, input int stop_at,
                      input int clr_at, input int rst_at,
                      input int restart_at, input int len);
    eo1p = p1; eo1np = p2;
    edges = 16'(e); div = 16'(d); dir = dr; mode = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= len; i++) begin
      stop  = (i == stop_at);
      clr   = (i == clr_at);
      rst   = (i == rst_at);
      start = (i == restart_at);
      edges = 16'($urandom_range(1, 20));
      div   = 16'($urandom_range(0, 7));
      dir   = 1'($urandom);
      mode  = 1'($urandom);
      tick();
    end
    stop = 0; clr = 0; rst = 0; start = 0;
    settle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    do_reset();
    chk("rst_busy", 32'(eo_busy), 32'd0);
    chk("rst_remain", 32'(remain), 32'd0);
    chk("rst_out", {30'd0, ec1po, ec1no}, 32'd0);

    // forward quadrature, 8 edges of 4 clocks
    scen(8, 4, 0, 0, 0, 0, 0, 0, 0, 0, 34);
    chk("q8_out", {30'd0, ec1po, ec1no}, 32'd0);

    // reverse, div 0 treated as 1
    scen(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 5);
    chk("rev3_out", {30'd0, ec1po, ec1no}, 32'b10);

    // pulse/direction, inverted direct output
    do_reset();
    scen(6, 2, 1, 1, 1, 0, 0, 0, 0, 0, 14);
    chk("pd_po", 32'(ec1po), 32'd1);
    chk("pd_no", 32'(ec1no), 32'd1);

    // abort after two edges, then resume from phase 2
    do_reset();
    scen(10, 5, 0, 0, 0, 0, 12, 0, 0, 0, 14);
    chk("stop_remain", 32'(remain), 32'd8);
    chk("stop_out", {30'd0, ec1po, ec1no}, 32'b11);
    chk("stop_busy", 32'(eo_busy), 32'd0);
    scen(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    chk("resume_out", {30'd0, ec1po, ec1no}, 32'd0);

    // logic clear and reset mid-run
    scen(100, 3, 0, 0, 0, 0, 0, 10, 0, 0, 12);
    chk("clr_remain", 32'(remain), 32'd0);
    chk("clr_busy", 32'(eo_busy), 32'd0);
    scen(100, 3, 1, 0, 0, 0, 0, 0, 10, 0, 12);
    chk("rst_mid_remain", 32'(remain), 32'd0);

    // zero-edge start
    edges = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 32'(eo_done), 32'd1);
    chk("zero_busy", 32'(eo_busy), 32'd0);
    tick();
    chk("zero_done_end", 32'(eo_done), 32'd0);

    // restart during run is ignored
    scen(5, 2, 0, 0, 0, 0, 0, 0, 0, 3, 6);
    chk("restart_remain", 32'(remain), 32'd0);

    for (int r = 0; r < 40; r++) begin
      int e, d, sa, ca, ra;
      e  = $urandom_range(0, 12);
      d  = $urandom_range(0, 4);
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      ca = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 30) : 0;
      ra = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
      scen(e, d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           sa, ca, 0, ra, e * ((d == 0) ? 1 : d) + 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_encoder_output.md
Name: channel_encoder_output

Overview:
- Quadrature encoder emulation channel for the advtim PE core. It is the transmit-side counterpart of the encoder input channel.
- Software loads an edge count, a per-edge period and a direction, then starts the channel.
- The block emits exactly that many edges on a direct/quadrature output pair, in either 4-edge quadrature or pulse/direction format.
- It reports busy, done and the remaining edge count.

Parameters:
- CNT_W, 16, width of the edge count and the remaining-edge register.
- DIV_W, 16, width of the per-edge period (in pe_enc_clk cycles).

Ports:
- pe_enc_clk  in  1  block clock.
- pe_enc_rst  in  1  reset.
- pe_enc_logic_clr  in  1  logic clear: same effect as reset, lower priority than reset.
- r_eo_start  in  1  single-cycle start request.
- r_eo_stop  in  1  abort request.
- r_eo_dir  in  1  direction: 0 forward, 1 reverse. Sampled at start.
- r_eo_mode  in  1  output format: 0 quadrature, 1 pulse/direction. Sampled at start.
- r_eo1p  in  1  direct output polarity invert. Static configuration.
- r_eo1np  in  1  quadrature output polarity invert. Static configuration.
- r_eo_edges  in  CNT_W  number of edges to emit. Sampled at start.
- r_eo_div  in  DIV_W  clocks per edge; 0 is treated as 1. Sampled at start.
- ec1po  out  1  direct channel output.
- ec1no  out  1  quadrature channel output (direction level in pulse/direction mode).
- eo_busy  out  1  high while the channel is emitting.
- eo_done  out  1  one-cycle pulse on normal completion.
- r_eo_remain  out  CNT_W  edges still to emit.

Behaviour:
- Reset: pe_enc_clk, synchronous, active-high on pe_enc_rst.
  - Takes state IDLE, phase=0, remain=0, divcnt=0.
  - Clears latched dir, mode and div.
  - eo_busy=0, eo_done=0. ec1po=r_eo1p, ec1no=r_eo1np.
- pe_enc_logic_clr has identical effect to reset. It overrides start and stop, including mid-run; eo_done is not pulsed.
- Phase register, 2 bits, holds raw (A,B):
  - Phase 0..3 = (0,0),(1,0),(1,1),(0,1).
  - Forward: phase+1 mod 4, so A rises while B is low.
  - Reverse: phase-1 mod 4.
  - Wrap 3->0 and 0->3 is seamless.
- Quadrature mode: raw A = phase A, raw B = phase B.
- Pulse/direction mode:
  - Raw A toggles on every edge, so 2 edges make 1 pulse.
  - Raw B = latched dir.
  - Phase register still steps and holds.
- Outputs: ec1po = raw A XOR r_eo1p; ec1no = raw B XOR r_eo1np. Raw values are registered; the polarity XOR is combinational.
- div_eff = (r_eo_div==0) ? 1 : r_eo_div.
- States: IDLE, RUN.
- IDLE:
  - On r_eo_start with r_eo_edges!=0: latch dir, mode and div_eff; set remain=r_eo_edges, divcnt=div_eff-1; go to RUN; eo_busy=1 from the next cycle.
  - On r_eo_start with r_eo_edges==0: stay IDLE, pulse eo_done the next cycle, outputs unchanged.
- RUN, each cycle:
  - If divcnt==0: step phase (emit edge), remain-=1, divcnt reloaded to div_eff-1.
  - Else: divcnt-=1.
  - When the edge that makes remain 0 is emitted: go to IDLE, eo_busy=0, and eo_done=1 for exactly the following cycle.
- Timing: with start sampled at clock T and N edges of period D, edge k (1..N) is registered at clock T+k*D. eo_done is high for the cycle after clock T+N*D.
- r_eo_start while in RUN is ignored. Latched config is not updated.
- r_eo_stop in RUN:
  - Go to IDLE at the next clock; no edge is emitted on that clock; no eo_done.
  - phase and remain hold their current values, so outputs hold their level.
- Simultaneous start and stop in IDLE: stop wins; no run starts.
- Stop on the clock where the final edge is due: stop wins; the edge is not emitted, remain=1, no eo_done.
- Phase persists across runs: a new run continues from the current phase with no output glitch.
- Config changes to r_eo_dir, r_eo_mode, r_eo_edges and r_eo_div during RUN have no effect.

Test Plan:
- Reset, then start with edges=8, div=4, dir=0, mode=0, no invert:
  - ec1po/ec1no step 00,10,11,01,00,10,11,01,00 at clocks T+4, T+8, …, T+32.
  - eo_done pulses at T+33; r_eo_remain decrements 8→0.
- Start with edges=3, div=0, dir=1, from phase 0: outputs go 01, 11, 10 on three consecutive clocks T+1..T+3; eo_done at T+4.
- Mode=1, edges=6, div=2, dir=1, r_eo1p=1: ec1no held 1; ec1po idles 1 and toggles 6 times at 2-clock spacing, ending at 1.
- Start edges=10, div=5, assert r_eo_stop at T+12:
  - Exactly 2 edges emitted; r_eo_remain=8; no eo_done; outputs hold.
  - A new start with edges=2 resumes from phase 2.
- pe_enc_logic_clr mid-run (edges=100, div=3) → next cycle: eo_busy=0, phase 0, r_eo_remain=0, no eo_done. Repeat the same scenario with pe_enc_rst.
- Start with edges=0 → eo_done pulse one cycle later, eo_busy stays 0. Start re-asserted during RUN → ignored, edge count unchanged.
